// File: rtl/tof_phase_sequencer.sv
// tof_phase_sequencer: double-buffered frame sequencer driving ToFClks with a per-phase stepped DELAY1.
// Optional back-to-back frames under TOF_SEQ_CONTINUOUS_EN (shadow address 10 bit0 = CONT).
module tof_phase_sequencer #(
  parameter int NUM_PHASES = 4,
  parameter int SETTLE     = 2
) (
  input  logic        i_clkin,
  input  logic        i_rstn,
  input  logic        i_start,
  input  logic        i_cfg_we,
  input  logic [3:0]  i_cfg_addr,
  input  logic [31:0] i_cfg_data,
  output logic        o_busy,
  output logic        o_done,
  output logic [2:0]  o_phase,
  output logic        o_valid,
  output logic [31:0] o_period,
  output logic [31:0] o_duty1,
  output logic [31:0] o_delay1,
  output logic [31:0] o_duty2,
  output logic [31:0] o_delay2,
  output logic [31:0] o_duty3,
  output logic [31:0] o_delay3
);
  localparam logic [31:0] SETTLE_M1 = 32'(SETTLE - 1);
  localparam logic [2:0]  LAST      = 3'(NUM_PHASES - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETUP, S_EXPOSE, S_GAP, S_FIN} state_t;

  state_t      r_state;
  logic [31:0] r_shadow [0:9];
  logic [31:0] r_period, r_duty1, r_delay1, r_duty2, r_delay2, r_duty3, r_delay3;
  logic [31:0] r_step, r_expose, r_gap, r_cnt;
  logic [2:0]  r_phase;
  logic        r_busy, r_done, r_valid;
  logic        w_cont;
  logic [32:0] w_sum;
  logic [31:0] w_delay1_next;

  // One conditional subtract keeps DELAY1 in [0, PERIOD) given base and step below PERIOD.
  assign w_sum         = {1'b0, r_delay1} + {1'b0, r_step};
  assign w_delay1_next = (w_sum >= {1'b0, r_period}) ? w_sum[31:0] - r_period : w_sum[31:0];

  always_ff @(posedge i_clkin or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < 10; i++) r_shadow[i] <= (i == 8) ? 32'd1 : 32'd0;
    end else if (i_cfg_we && i_cfg_addr < 4'd10) begin
      r_shadow[i_cfg_addr] <= i_cfg_data;
    end
  end

`ifdef TOF_SEQ_CONTINUOUS_EN
  logic r_cont;
  always_ff @(posedge i_clkin or negedge i_rstn) begin
    if (!i_rstn) r_cont <= 1'b0;
    else if (i_cfg_we && i_cfg_addr == 4'd10) r_cont <= i_cfg_data[0];
  end
  assign w_cont = r_cont;
`else
  assign w_cont = 1'b0;
`endif

  always_ff @(posedge i_clkin or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_valid  <= 1'b0;
      r_phase  <= 3'd0;
      r_cnt    <= 32'd0;
      r_period <= 32'd0;
      r_duty1  <= 32'd0;
      r_delay1 <= 32'd0;
      r_duty2  <= 32'd0;
      r_delay2 <= 32'd0;
      r_duty3  <= 32'd0;
      r_delay3 <= 32'd0;
      r_step   <= 32'd0;
      r_expose <= 32'd0;
      r_gap    <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_state <= S_LOAD;
          r_busy  <= 1'b1;
        end
        S_LOAD: begin
          r_period <= r_shadow[0];
          r_duty1  <= r_shadow[1];
          r_delay1 <= r_shadow[2];
          r_duty2  <= r_shadow[3];
          r_delay2 <= r_shadow[4];
          r_duty3  <= r_shadow[5];
          r_delay3 <= r_shadow[6];
          r_step   <= r_shadow[7];
          r_expose <= r_shadow[8];
          r_gap    <= r_shadow[9];
          r_phase  <= 3'd0;
          r_cnt    <= SETTLE_M1;
          r_state  <= S_SETUP;
        end
        S_SETUP: if (r_cnt == 32'd0) begin
          r_state <= S_EXPOSE;
          r_valid <= 1'b1;
          r_cnt   <= (r_expose == 32'd0) ? 32'd0 : r_expose - 32'd1;
        end else r_cnt <= r_cnt - 32'd1;
        S_EXPOSE: if (r_cnt != 32'd0) r_cnt <= r_cnt - 32'd1;
        else begin
          r_valid <= 1'b0;
          if (r_phase == LAST) begin
            r_state <= S_FIN;
            r_done  <= 1'b1;
            r_busy  <= w_cont;
          end else if (r_gap != 32'd0) begin
            r_state <= S_GAP;
            r_cnt   <= r_gap - 32'd1;
          end else begin
            r_state  <= S_SETUP;
            r_cnt    <= SETTLE_M1;
            r_phase  <= r_phase + 3'd1;
            r_delay1 <= w_delay1_next;
          end
        end
        S_GAP: if (r_cnt != 32'd0) r_cnt <= r_cnt - 32'd1;
        else begin
          r_state  <= S_SETUP;
          r_cnt    <= SETTLE_M1;
          r_phase  <= r_phase + 3'd1;
          r_delay1 <= w_delay1_next;
        end
        S_FIN: begin
          r_done  <= 1'b0;
          r_state <= r_busy ? S_LOAD : S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_valid  = r_valid;
  assign o_phase  = r_phase;
  assign o_period = r_period;
  assign o_duty1  = r_duty1;
  assign o_delay1 = r_delay1;
  assign o_duty2  = r_duty2;
  assign o_delay2 = r_delay2;
  assign o_duty3  = r_duty3;
  assign o_delay3 = r_delay3;
endmodule

// File: tb/tb_tof_phase_sequencer.sv
// tb_tof_phase_sequencer: randomized frames checked against a cycle-position model of the frame schedule.
module tb_tof_phase_sequencer;
  localparam int N = 4;
  localparam int S = 2;

  logic        clk = 1'b0, rstn = 1'b0, start = 1'b0, we = 1'b0;
  logic [3:0]  addr = 4'd0;
  logic [31:0] data = 32'd0;
  logic        busy, done, valid;
  logic [2:0]  phase;
  logic [31:0] period, duty1, delay1, duty2, delay2, duty3, delay3;
  int          n_chk = 0, n_pass = 0;

  tof_phase_sequencer #(.NUM_PHASES(N), .SETTLE(S)) dut (
    .i_clkin(clk), .i_rstn(rstn), .i_start(start), .i_cfg_we(we), .i_cfg_addr(addr),
    .i_cfg_data(data), .o_busy(busy), .o_done(done), .o_phase(phase), .o_valid(valid),
    .o_period(period), .o_duty1(duty1), .o_delay1(delay1), .o_duty2(duty2),
    .o_delay2(delay2), .o_duty3(duty3), .o_delay3(delay3)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; addr = a; data = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_chk++;
    if ({busy, done, valid, phase} !== 6'd0) $display("FAIL reset_ctrl got %b exp 000000", {busy, done, valid, phase});
    else n_pass++;
    n_chk++;
    if ((period | duty1 | delay1 | duty2 | delay2 | duty3 | delay3) !== 32'd0) $display("FAIL reset_cfg got nonzero cfg outputs exp 0");
    else n_pass++;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_frames();
    longint unsigned per, base, stp, ex, gp, ee, len, kk, o, ed1;
    logic [31:0] d1, d3;
    logic e_busy, e_done, e_valid;
    for (int t = 0; t < 7; t++) begin
      case (t)
        0: begin per = 100; base = 10; stp = 25; ex = 5; gp = 3; end
        1: begin per = 100; base = 90; stp = 30; ex = 5; gp = 3; end
        2: begin per = 100; base = 10; stp = 25; ex = 0; gp = 0; end
        default: begin
          per = $urandom_range(1, 1000); base = $urandom_range(0, 32'(per) - 1);
          stp = $urandom_range(0, 32'(per) - 1); ex = $urandom_range(0, 4); gp = $urandom_range(0, 3);
        end
      endcase
      d1 = $urandom; d3 = $urandom;
      wr(0, 32'(per)); wr(1, d1); wr(2, 32'(base)); wr(6, d3);
      wr(7, 32'(stp)); wr(8, 32'(ex)); wr(9, 32'(gp)); wr(12, $urandom);
      ee  = (ex == 0) ? 1 : ex;
      len = 1 + N * (S + ee) + (N - 1) * gp + 1;
      pulse_start();
      for (int c = 1; c <= int'(len) + 1; c++) begin
        kk = 0; o = 0;
        if (c >= 2) begin
          kk = (c >= len) ? N - 1 : (c - 2) / (S + ee + gp);
          o  = (c - 2) % (S + ee + gp);
        end
        e_busy  = c < len;
        e_done  = c == len;
        e_valid = c >= 2 && c < len && o >= S && o < S + ee;
        ed1     = (base + kk * stp) % per;
        n_chk++;
        if (busy !== e_busy) $display("FAIL busy t=%0d c=%0d got %b exp %b", t, c, busy, e_busy);
        else n_pass++;
        n_chk++;
        if (done !== e_done) $display("FAIL done t=%0d c=%0d got %b exp %b", t, c, done, e_done);
        else n_pass++;
        n_chk++;
        if (valid !== e_valid) $display("FAIL valid t=%0d c=%0d got %b exp %b", t, c, valid, e_valid);
        else n_pass++;
        if (c >= 2) begin
          n_chk++;
          if (phase !== 3'(kk)) $display("FAIL phase t=%0d c=%0d got %0d exp %0d", t, c, phase, kk);
          else n_pass++;
          n_chk++;
          if (delay1 !== 32'(ed1)) $display("FAIL delay1 t=%0d c=%0d got %0d exp %0d", t, c, delay1, ed1);
          else n_pass++;
          n_chk++;
          if ({period, duty1, delay3} !== {32'(per), d1, d3}) $display("FAIL const_cfg t=%0d c=%0d got %h exp %h", t, c, {period, duty1, delay3}, {32'(per), d1, d3});
          else n_pass++;
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_write_during_frame();
    int nv, nd, dat;
    wr(0, 100); wr(8, 5); wr(9, 0);
    pulse_start();
    nv = 0; nd = 0; dat = 0;
    for (int c = 1; c <= 35; c++) begin
      nv += int'(valid);
      if (done) begin nd++; dat = c; end
      we    = (c == 3);
      addr  = 4'd8;
      data  = 32'd9;
      start = (c == 5);
      @(negedge clk);
    end
    we = 1'b0; start = 1'b0;
    n_chk++;
    if (nv != 20 || nd != 1 || dat != 30) $display("FAIL old_expose got nv=%0d nd=%0d at=%0d exp nv=20 nd=1 at=30", nv, nd, dat);
    else n_pass++;
    pulse_start();
    nv = 0; nd = 0; dat = 0;
    for (int c = 1; c <= 50; c++) begin
      nv += int'(valid);
      if (done) begin nd++; dat = c; end
      @(negedge clk);
    end
    n_chk++;
    if (nv != 36 || nd != 1 || dat != 46) $display("FAIL new_expose got nv=%0d nd=%0d at=%0d exp nv=36 nd=1 at=46", nv, nd, dat);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    int nv, dat;
    wr(0, 100); wr(2, 10); wr(7, 25); wr(8, 5); wr(9, 3);
    pulse_start();
    repeat (25) @(negedge clk);
    n_chk++;
    if (valid !== 1'b1 || phase !== 3'd2) $display("FAIL third_expose got valid=%b phase=%0d exp valid=1 phase=2", valid, phase);
    else n_pass++;
    #1 rstn = 1'b0;
    #1;
    n_chk++;
    if ({valid, busy, done} !== 3'b000) $display("FAIL async_reset got %b exp 000", {valid, busy, done});
    else n_pass++;
    @(negedge clk);
    rstn = 1'b1;
    pulse_start();
    nv = 0; dat = 0;
    for (int c = 1; c <= 16; c++) begin
      nv += int'(valid);
      if (done) dat = c;
      if (c == 3) begin
        n_chk++;
        if (period !== 32'd0 || delay1 !== 32'd0) $display("FAIL shadow_reset got period=%0d delay1=%0d exp 0 0", period, delay1);
        else n_pass++;
      end
      @(negedge clk);
    end
    n_chk++;
    if (nv != 4 || dat != 14) $display("FAIL reset_frame got nv=%0d at=%0d exp nv=4 at=14", nv, dat);
    else n_pass++;
  endtask

`ifdef TOF_SEQ_CONTINUOUS_EN
  task automatic test_continuous();
    wr(8, 1); wr(9, 0); wr(10, 1);
    pulse_start();
    for (int c = 1; c <= 30; c++) begin
      n_chk++;
      if (busy !== (c < 28) || done !== (c == 14 || c == 28)) $display("FAIL continuous c=%0d got busy=%b done=%b", c, busy, done);
      else n_pass++;
      we = (c == 20); addr = 4'd10; data = 32'd0;
      @(negedge clk);
    end
    we = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_frames();
    test_write_during_frame();
    test_reset_mid_frame();
`ifdef TOF_SEQ_CONTINUOUS_EN
    test_continuous();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
